// File: rtl/bsg_mul_iterative_issue.sv
// Tagged request/response adapter in front of an iterative multiplier: issues operands,
// captures the 2*width_p product, selects/corrects the requested half. Optional macro:
// BSG_MUL_ISSUE_ZERO_BYPASS_EN (zero operand completes without a multiplier handshake).
module bsg_mul_iterative_issue #(
  parameter int width_p     = 64,
  parameter int tag_width_p = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [2:0]             op_i,
  input  logic [width_p-1:0]     opA_i,
  input  logic [width_p-1:0]     opB_i,
  input  logic [tag_width_p-1:0] tag_i,
  input  logic                   flush_i,
  output logic                   mul_v_o,
  input  logic                   mul_ready_i,
  output logic [width_p-1:0]     mul_opA_o,
  output logic [width_p-1:0]     mul_opB_o,
  output logic                   mul_signed_o,
  input  logic                   mul_v_i,
  input  logic [2*width_p-1:0]   mul_result_i,
  output logic                   mul_yumi_o,
  output logic                   v_o,
  output logic [width_p-1:0]     result_o,
  output logic [tag_width_p-1:0] tag_o,
  input  logic                   yumi_i,
  output logic [2:0]             state_o
);

  // Handshakes: a transfer happens on a rising clk_i edge where valid and ready/yumi are
  // both high; valid never depends on ready, and the payload is held while valid waits.

  typedef enum logic [2:0] {
    eIdle  = 3'd0,
    eIssue = 3'd1,
    eWait  = 3'd2,
    eFix   = 3'd3,
    eOut   = 3'd4
  } state_e;

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_MULW   = 3'b100;

  state_e                 state_r, state_n;
  logic [2:0]             op_r;
  logic [width_p-1:0]     opA_r, opB_r, result_r;
  logic [tag_width_p-1:0] tag_r;
  logic                   signed_r, drop_r;
  logic                   accept, bypass;
  logic [width_p-1:0]     sel_prod;

`ifdef BSG_MUL_ISSUE_ZERO_BYPASS_EN
  assign bypass = (opA_i == '0) || (opB_i == '0);
`else
  assign bypass = 1'b0;
`endif

  assign accept = (state_r == eIdle) && v_i && !flush_i;

  always_comb begin
    state_n    = state_r;
    ready_o    = 1'b0;
    mul_v_o    = 1'b0;
    mul_yumi_o = 1'b0;
    v_o        = 1'b0;
    case (state_r)
      eIdle: begin
        ready_o = !flush_i;
        if (accept) state_n = bypass ? eOut : eIssue;
      end
      eIssue: begin
        // Withholding valid during flush keeps the multiplier from starting an orphan op.
        mul_v_o = !flush_i;
        if (flush_i)          state_n = eIdle;
        else if (mul_ready_i) state_n = eWait;
      end
      eWait: begin
        mul_yumi_o = mul_v_i;
        if (mul_v_i) begin
          if (drop_r || flush_i)      state_n = eIdle;
          else if (op_r == OP_MULHSU) state_n = eFix;
          else                        state_n = eOut;
        end
      end
      eFix: state_n = (drop_r || flush_i) ? eIdle : eOut;
      eOut: begin
        v_o = 1'b1;
        if (yumi_i || flush_i) state_n = eIdle;
      end
      default: state_n = eIdle;
    endcase
  end

  always_comb begin
    sel_prod = mul_result_i[width_p-1:0];
    case (op_r)
      OP_MULH, OP_MULHSU, OP_MULHU: sel_prod = mul_result_i[2*width_p-1:width_p];
      OP_MULW: sel_prod = {{(width_p-32){mul_result_i[31]}}, mul_result_i[31:0]};
      default: sel_prod = mul_result_i[width_p-1:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= eIdle;
      op_r     <= '0;
      opA_r    <= '0;
      opB_r    <= '0;
      tag_r    <= '0;
      signed_r <= 1'b0;
      result_r <= '0;
      drop_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        op_r     <= op_i;
        opA_r    <= opA_i;
        opB_r    <= opB_i;
        tag_r    <= tag_i;
        signed_r <= (op_i == OP_MULH);
        if (bypass) result_r <= '0;
      end
      if (state_r == eWait && mul_v_i) result_r <= sel_prod;
      // MULHSU runs unsigned; a negative rs1 over-counts the high half by rs2.
      if (state_r == eFix) result_r <= result_r - (opA_r[width_p-1] ? opB_r : '0);
      if (state_n == eIdle)
        drop_r <= 1'b0;
      else if (flush_i && (state_r == eWait || state_r == eFix))
        drop_r <= 1'b1;
    end
  end

  assign mul_opA_o    = opA_r;
  assign mul_opB_o    = opB_r;
  assign mul_signed_o = signed_r;
  assign result_o     = result_r;
  assign tag_o        = tag_r;
  assign state_o      = state_r;

  // A product offered outside eWait is a multiplier protocol error; it is never consumed.
  a_mul_v_only_in_wait: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    mul_v_i |-> (state_r == eWait));

endmodule

// File: tb/tb_bsg_mul_iterative_issue.sv
// Directed bench for bsg_mul_iterative_issue with a behavioural 3-cycle iterative multiplier.
module tb_bsg_mul_iterative_issue;
  localparam int W  = 64;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v_i = 1'b0, ready_o;
  logic [2:0]    op_i = '0;
  logic [W-1:0]  opA_i = '0, opB_i = '0;
  logic [TW-1:0] tag_i = '0;
  logic          flush_i = 1'b0;
  logic          mul_v_o, mul_ready_i, mul_signed_o, mul_yumi_o;
  logic [W-1:0]  mul_opA_o, mul_opB_o;
  logic          mul_v_i;
  logic [2*W-1:0] mul_result_i;
  logic          v_o;
  logic [W-1:0]  result_o;
  logic [TW-1:0] tag_o;
  logic          yumi_i = 1'b0;
  logic [2:0]    state_o;

  int checks = 0;
  int errors = 0;

  // clock/reset block
  always #5 clk = ~clk;

  bsg_mul_iterative_issue #(.width_p(W), .tag_width_p(TW)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
    .opA_i(opA_i), .opB_i(opB_i), .tag_i(tag_i), .flush_i(flush_i),
    .mul_v_o(mul_v_o), .mul_ready_i(mul_ready_i), .mul_opA_o(mul_opA_o),
    .mul_opB_o(mul_opB_o), .mul_signed_o(mul_signed_o), .mul_v_i(mul_v_i),
    .mul_result_i(mul_result_i), .mul_yumi_o(mul_yumi_o), .v_o(v_o),
    .result_o(result_o), .tag_o(tag_o), .yumi_i(yumi_i), .state_o(state_o)
  );

  // behavioural iterative multiplier
  logic           busy, sgn_seen;
  logic [1:0]     cnt;
  logic [2*W-1:0] prod;
  int             hs_cnt, yumi_cnt;

  assign mul_ready_i  = !busy;
  assign mul_result_i = mul_v_i ? prod : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; mul_v_i <= 1'b0; cnt <= '0; prod <= '0;
      hs_cnt <= 0; yumi_cnt <= 0; sgn_seen <= 1'b0;
    end else begin
      if (mul_v_o && !busy) begin
        busy     <= 1'b1;
        cnt      <= 2'd3;
        hs_cnt   <= hs_cnt + 1;
        sgn_seen <= mul_signed_o;
        if (mul_signed_o)
          prod <= $signed({{W{mul_opA_o[W-1]}}, mul_opA_o}) * $signed({{W{mul_opB_o[W-1]}}, mul_opB_o});
        else
          prod <= {{W{1'b0}}, mul_opA_o} * {{W{1'b0}}, mul_opB_o};
      end else if (busy && !mul_v_i) begin
        if (cnt == 2'd1) mul_v_i <= 1'b1;
        else cnt <= cnt - 2'd1;
      end
      if (mul_v_i && mul_yumi_o) begin
        mul_v_i  <= 1'b0;
        busy     <= 1'b0;
        yumi_cnt <= yumi_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // driver: issue one op, wait for v_o, optionally hold yumi low, then retire
  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tg, input logic [W-1:0] exp,
                       input logic exp_sgn, input int exp_fix, input int hold);
    int fix = 0;
    int k;
    logic stable = 1'b1, rdy_low = 1'b1;
    logic [W-1:0] r0;
    logic [TW-1:0] t0;
    @(negedge clk);
    v_i = 1'b1; op_i = op; opA_i = a; opB_i = b; tag_i = tg;
    #1 check({name, "_ready"}, ready_o, 1'b1);
    @(negedge clk);
    v_i = 1'b0;
    for (k = 0; k < 60; k++) begin
      if (state_o == 3'd3) fix++;
      if (v_o) break;
      @(negedge clk);
    end
    check({name, "_v_o"}, v_o, 1'b1);
    check({name, "_result"}, result_o, exp);
    check({name, "_tag"}, tag_o, tg);
    check({name, "_signed"}, sgn_seen, exp_sgn);
    check({name, "_fix_cycles"}, fix, exp_fix);
    r0 = result_o; t0 = tag_o;
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (result_o !== r0 || tag_o !== t0 || v_o !== 1'b1) stable = 1'b0;
        if (ready_o !== 1'b0) rdy_low = 1'b0;
      end
      check({name, "_hold_stable"}, stable, 1'b1);
      check({name, "_hold_ready_low"}, rdy_low, 1'b1);
    end
    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    check({name, "_retired_v_o"}, v_o, 1'b0);
    check({name, "_retired_ready"}, ready_o, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int y0, h0;
    logic v_seen;
    // reset state
    #12;
    check("rst_ready", ready_o, 1'b1);
    check("rst_v_o", v_o, 1'b0);
    check("rst_mul_v_o", mul_v_o, 1'b0);
    check("rst_mul_yumi", mul_yumi_o, 1'b0);
    check("rst_result", result_o, '0);
    check("rst_tag", tag_o, '0);
    check("rst_mul_ops", {mul_opA_o, mul_opB_o, mul_signed_o}, '0);
    check("rst_state", state_o, 3'd0);
    @(negedge clk); rst_n = 1'b1;

    // directed vectors with hand-computed results
    do_op("mulh",   3'b001, -64'sd3, 64'd5, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0);
    do_op("mulhsu", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 0);
    do_op("mulhu",  3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, 0);
    do_op("mul_ones", 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd18, 64'h1, 1'b0, 0, 0);
    do_op("mulw",   3'b100, 64'h4000_0000, 64'd2, 5'd21, 64'hFFFF_FFFF_8000_0000, 1'b0, 0, 0);
    do_op("op111",  3'b111, 64'd11, 64'd13, 5'd22, 64'd143, 1'b0, 0, 0);

    // flush while waiting for the product
    y0 = yumi_cnt;
    @(negedge clk);
    v_i = 1'b1; op_i = 3'b000; opA_i = 64'd9; opB_i = 64'd9; tag_i = 5'd30;
    @(negedge clk);
    v_i = 1'b0;
    for (int k = 0; k < 20 && state_o != 3'd2; k++) @(negedge clk);
    check("flush_reached_wait", state_o, 3'd2);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    v_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (v_o) v_seen = 1'b1;
      @(negedge clk);
    end
    check("flush_no_v_o", v_seen, 1'b0);
    check("flush_product_yumid", yumi_cnt - y0, 1);
    check("flush_ready", ready_o, 1'b1);
    do_op("after_flush", 3'b000, 64'd7, 64'd6, 5'd31, 64'd42, 1'b0, 0, 0);

    // backpressure in eOut
    do_op("backpressure", 3'b000, 64'd100, 64'd3, 5'd12, 64'd300, 1'b0, 0, 10);

    // flush while the result is held
    @(negedge clk);
    v_i = 1'b1; op_i = 3'b000; opA_i = 64'd5; opB_i = 64'd5; tag_i = 5'd4;
    @(negedge clk);
    v_i = 1'b0;
    for (int k = 0; k < 20 && !v_o; k++) @(negedge clk);
    check("flush_out_v_o", v_o, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("flush_out_cleared", {v_o, ready_o}, 2'b01);

    // zero operand
    h0 = hs_cnt;
`ifdef BSG_MUL_ISSUE_ZERO_BYPASS_EN
    @(negedge clk);
    v_i = 1'b1; op_i = 3'b000; opA_i = '0; opB_i = 64'd123; tag_i = 5'd8;
    @(negedge clk);
    v_i = 1'b0;
    check("bypass_v_o", v_o, 1'b1);
    check("bypass_result", result_o, '0);
    check("bypass_tag", tag_o, 5'd8);
    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    check("bypass_no_handshake", hs_cnt - h0, 0);
`else
    do_op("zero_op", 3'b000, '0, 64'd123, 5'd8, '0, 1'b0, 0, 0);
    check("zero_op_handshake", hs_cnt - h0, 1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
